booth_mul_arbiter: RTL
======================

Name: booth_mul_arbiter

Overview:
- Shares one sequential Booth multiplier unit between two independent requesters.
- Accepts operand pairs over valid/ready handshakes and grants access round-robin.
- Launches the multiplier, holds its operands stable, captures the product on done, and returns it to the granting requester over a response handshake.
- A watchdog flags a multiplier that never signals done.

Parameters:
- W, 4: operand width; the product is 2*W bits.
- TIMEOUT, 32: maximum cycles in BUSY before an error response is returned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_x  in  W  requester 0 multiplicand.
- req0_y  in  W  requester 0 multiplier.
- req1_valid, req1_ready, req1_x, req1_y: as above, for requester 1.
- rsp0_valid  out  1  response pending for requester 0.
- rsp0_ready  in  1  requester 0 takes the response.
- rsp1_valid  out  1  response pending for requester 1.
- rsp1_ready  in  1  requester 1 takes the response.
- rsp_prod  out  2W  product; shared by both response channels.
- rsp_err  out  1  response is a timeout error; rsp_prod is 0 when set.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  W  multiplicand to the multiplier.
- mul_y  out  W  multiplier operand to the multiplier.
- mul_done  in  1  multiplier done; may stay high for several cycles.
- mul_prod  in  2W  multiplier result; valid while mul_done is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; op_x and op_y 0; owner 0; last_grant 1, so requester 0 wins the first tie; watchdog counter 0. Reset applies in any state and abandons any in-flight operation with no response.
- IDLE:
  - Grant when at least one reqN_valid is high.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not equal to last_grant.
  - reqN_ready = 1 for the granted requester in this cycle only; it is combinational from state and valids.
  - At the clock edge: op_x/op_y <= that requester's x/y; owner <= N; last_grant <= N; state -> LAUNCH.
- LAUNCH: mul_start = 1 for exactly one cycle -> BUSY. Counter is cleared.
- BUSY:
  - Counter increments each cycle.
  - If mul_done = 1: rsp_prod <= mul_prod, rsp_err <= 0, -> RESP.
  - Else, if the counter reaches TIMEOUT-1: rsp_prod <= 0, rsp_err <= 1, -> RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp{owner}_valid = 1; the other rsp valid is 0.
  - rsp_prod and rsp_err are held stable.
  - Leave only when rsp{owner}_ready = 1, then -> DRAIN. Backpressure can last indefinitely.
- DRAIN: wait until mul_done = 0, then -> IDLE. This prevents a multi-cycle done from completing the next operation early.
- mul_x/mul_y are driven from op_x/op_y in all states and are stable from LAUNCH through DRAIN. The multiplier loads operands several cycles after start.
- reqN_ready is never asserted outside IDLE; requests held valid meanwhile wait.
- Latency: acceptance at cycle T, mul_start at T+1. If mul_done first rises at cycle D, rspN_valid rises at D+1. Minimum turnaround from response taken to next acceptance is 2 cycles, assuming mul_done is already low.
- The watchdog counter is $clog2(TIMEOUT+1) bits and never wraps; it is cleared in LAUNCH.
- Products are passed through unmodified; signedness belongs to the multiplier.

Test Plan:
- Single request, multiplier model with done at cycle 13 after start, held 2 cycles: req0 x=3, y=-2 (4'hE) -> req0_ready at T; mul_start one cycle at T+1; mul_x=3, mul_y=E stable until IDLE; rsp0_valid with rsp_prod=8'hFA, rsp_err=0; rsp1_valid stays 0.
- Both requesters valid continuously: req0 (2,3), req1 (-1,-1) -> grants alternate 0,1,0,1; the first grant after reset is to requester 0; products 8'h06 and 8'h01 are routed to the correct rsp channel.
- Response backpressure: rsp0_ready held 0 for 20 cycles -> rsp0_valid and rsp_prod stay stable, no new grant, req1_ready stays 0; ready=1 -> DRAIN, then IDLE, then req1 is granted.
- Multiplier never asserts done, TIMEOUT=32 -> rsp_err=1 and rsp_prod=0 exactly 32 cycles after BUSY entry; the arbiter then accepts new requests.
- mul_done held high 5 cycles after the response is taken -> the arbiter stays in DRAIN until done falls; the next operation does not complete from the stale done.
- rst asserted in BUSY and again in RESP -> all outputs 0 on the next cycle, no response issued, last_grant=1; the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier between two
// requesters, with operand hold, product capture and a done watchdog.
module booth_mul_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_prod,
  output logic           rsp_err,
  output logic           mul_start,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_prod,
  output logic           busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     op_x_q, op_x_d;
  logic [W-1:0]     op_y_q, op_y_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic             err_q, err_d;

  logic             grant_vld;
  logic             grant_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_x_q       <= '0;
      op_y_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
    end
  end

  // On a tie the requester that did not win last time is served.
  assign grant_vld = req0_valid | req1_valid;
  assign grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    err_d        = err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mul_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req0_ready   = ~grant_sel;
          req1_ready   = grant_sel;
          op_x_d       = grant_sel ? req1_x : req0_x;
          op_y_d       = grant_sel ? req1_y : req0_y;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q < CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (mul_done) begin
          prod_d  = mul_prod;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A done held over from the previous operation must not leak into the next one.
        if (!mul_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign rsp_prod   = prod_q;
  assign rsp_err    = err_q;
  assign mul_x      = op_x_q;
  assign mul_y      = op_y_q;
  assign busy       = (state_q != S_IDLE);

endmodule
